// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states and grant owners.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package memory_arbiter_pkg;

    // Arbiter FSM: one transaction in flight, one response cycle after completion
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Owner of the most recent grant, used for round-robin tie breaking
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // On a tie the requester that did not win last time gets the memory
    function automatic grant_t tie_winner(input grant_t last);
        return (last == GRANT_I) ? GRANT_D : GRANT_I;
    endfunction

endpackage

// File: rtl/memory_arbiter_bus_timeout_counter.sv
// Counts memory wait cycles and flags a hung access.
// Latency: expired is combinational, high in the TIMEOUT_CYCLES-th counted cycle.
// Backpressure: none; clear has priority over count_en.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            // Timeout switched off: inputs are intentionally ignored
            logic w_unused;
            assign w_unused = &{1'b0, clk, reset, clear, count_en};
            assign expired  = 1'b0;
        end else begin : g_enabled
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            logic [CW-1:0] r_count;

            // Count wait cycles; the waiting state is left on expiry, so the clear
            // in the following cycle keeps the count within range
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_count <= '0;
                end else if (clear) begin
                    r_count <= '0;
                end else if (count_en) begin
                    r_count <= r_count + 1'b1;
                end
            end

            // Fires in the cycle that would complete TIMEOUT_CYCLES unanswered waits
            assign expired = count_en && (r_count == CW'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and load/store.
// Latency: request sampled in cycle 0, mem_req from cycle 1, ack in cycle k gives ready in cycle k+1.
// Backpressure: requesters hold req until their ready pulse; memory stalls via a late mem_ack.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    // fetch requester
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_ready,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    // load/store requester
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_ready,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    // shared memory
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    // error reporting
    output logic                    bus_err,
    output logic                    bus_err_sticky
);

    localparam int STRB_W = DATA_WIDTH / 8;

    state_t                  r_state;
    grant_t                  r_last_grant;
    logic                    r_i_ready;
    logic                    r_d_ready;
    logic [DATA_WIDTH-1:0]   r_i_rdata;
    logic [DATA_WIDTH-1:0]   r_d_rdata;
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;
    logic [STRB_W-1:0]       r_mem_wstrb;
    logic                    r_bus_err;
    logic                    r_bus_err_sticky;

    logic                    w_i_req_m;
    logic                    w_d_req_m;
    logic                    w_grant_any;
    logic                    w_grant_d;
    logic                    w_busy;
    logic                    w_expired;

    // A requester whose ready is pulsing this cycle is not treated as a new request
    assign w_i_req_m   = i_req & ~r_i_ready;
    assign w_d_req_m   = d_req & ~r_d_ready;
    assign w_grant_any = w_i_req_m | w_d_req_m;
    assign w_grant_d   = w_d_req_m & (~w_i_req_m | (tie_winner(r_last_grant) == GRANT_D));
    assign w_busy      = (r_state == BUSY_I) || (r_state == BUSY_D);

    bus_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (~w_busy),
        .count_en (w_busy & ~mem_ack),
        .expired  (w_expired)
    );

    // Arbitration FSM with all outputs registered; ready/bus_err are single-cycle pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_last_grant     <= GRANT_I;
            r_i_ready        <= 1'b0;
            r_d_ready        <= 1'b0;
            r_i_rdata        <= '0;
            r_d_rdata        <= '0;
            r_mem_req        <= 1'b0;
            r_mem_we         <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_wdata      <= '0;
            r_mem_wstrb      <= '0;
            r_bus_err        <= 1'b0;
            r_bus_err_sticky <= 1'b0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_bus_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_any) begin
                        r_mem_req    <= 1'b1;
                        r_mem_addr   <= w_grant_d ? d_addr : i_addr;
                        r_mem_we     <= w_grant_d & d_we;
                        r_mem_wdata  <= w_grant_d ? d_wdata : '0;
                        r_mem_wstrb  <= (w_grant_d && d_we) ? d_wstrb : '0;
                        r_last_grant <= w_grant_d ? GRANT_D : GRANT_I;
                        r_state      <= w_grant_d ? BUSY_D : BUSY_I;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // Ack wins over a simultaneous expiry: the access did complete
                    if (mem_ack || w_expired) begin
                        r_mem_req <= 1'b0;
                        r_state   <= RESP;
                        if (!mem_ack) begin
                            r_bus_err        <= 1'b1;
                            r_bus_err_sticky <= 1'b1;
                        end
                        if (r_state == BUSY_I) begin
                            r_i_ready <= 1'b1;
                            r_i_rdata <= mem_ack ? mem_rdata : '0;
                        end else begin
                            r_d_ready <= 1'b1;
                            if (!r_mem_we) begin
                                r_d_rdata <= mem_ack ? mem_rdata : '0;
                            end
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign i_ready        = r_i_ready;
    assign i_rdata        = r_i_rdata;
    assign d_ready        = r_d_ready;
    assign d_rdata        = r_d_rdata;
    assign mem_req        = r_mem_req;
    assign mem_we         = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;
    assign mem_wstrb      = r_mem_wstrb;
    assign bus_err        = r_bus_err;
    assign bus_err_sticky = r_bus_err_sticky;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small memory responder.
// Latency: each step is one clock; outputs sampled 1ns after the rising edge.
// Backpressure: memory ack delay is set per test; timeout uses TIMEOUT_CYCLES=8.
module tb_memory_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        bus_err;
    logic        bus_err_sticky;

    int n_checks = 0;
    int n_fail   = 0;
    int i_cnt    = 0;
    int d_cnt    = 0;

    // memory responder controls
    logic mem_auto  = 1'b1;
    logic force_ack = 1'b0;
    int   mem_delay = 0;

    memory_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_ready        (i_ready),
        .i_rdata        (i_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_wstrb        (d_wstrb),
        .d_ready        (d_ready),
        .d_rdata        (d_rdata),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .bus_err        (bus_err),
        .bus_err_sticky (bus_err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Memory: acks after mem_delay extra wait cycles; read data is addr ^ 0x113
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!mem_auto) begin
                mem_ack  = force_ack;
                wait_cnt = 0;
            end else if (mem_req) begin
                if (wait_cnt == mem_delay) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                end else begin
                    mem_ack  = 1'b0;
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
            mem_rdata = mem_addr ^ 32'h113;
        end
    end

    // Ready pulse counters
    initial begin
        forever begin
            @(negedge clk);
            if (i_ready) i_cnt = i_cnt + 1;
            if (d_ready) d_cnt = d_cnt + 1;
        end
    end

    initial begin
        int base_i;
        int base_d;
        logic [31:0] cur_addr;

        reset = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        #1 reset = 1'b0;
        #2;
        check("rst_i_ready",   i_ready,        0);
        check("rst_d_ready",   d_ready,        0);
        check("rst_i_rdata",   i_rdata,        0);
        check("rst_d_rdata",   d_rdata,        0);
        check("rst_mem_req",   mem_req,        0);
        check("rst_mem_we",    mem_we,         0);
        check("rst_mem_addr",  mem_addr,       0);
        check("rst_mem_wdata", mem_wdata,      0);
        check("rst_mem_wstrb", mem_wstrb,      0);
        check("rst_bus_err",   bus_err,        0);
        check("rst_sticky",    bus_err_sticky, 0);
        tick; tick;
        reset = 1'b1;

        // Tie arbitration: D wins first after reset, then alternates D,I,D,I
        mem_delay = 0;
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        for (int c = 1; c <= 12; c++) begin
            tick;
            check("arb_i_ready", i_ready, (c == 5 || c == 11));
            check("arb_d_ready", d_ready, (c == 2 || c == 8));
            if (c % 3 == 1) begin
                check("arb_mem_req",  mem_req, 1);
                check("arb_mem_addr", mem_addr, (c == 1 || c == 7) ? 32'h80 : 32'h40);
            end else begin
                check("arb_mem_idle", mem_req, 0);
            end
            if (c == 11) begin
                i_req = 1'b0; d_req = 1'b0;
            end
        end
        check("arb_i_rdata", i_rdata, 32'h153);
        check("arb_d_rdata", d_rdata, 32'h193);

        // Fetch only, zero-wait memory
        base_d = d_cnt;
        i_req = 1'b1; i_addr = 32'h100;
        tick;
        check("f_mem_req",   mem_req,   1);
        check("f_mem_addr",  mem_addr,  32'h100);
        check("f_mem_we",    mem_we,    0);
        check("f_mem_wstrb", mem_wstrb, 0);
        check("f_i_ready0",  i_ready,   0);
        tick;
        check("f_i_ready",   i_ready,   1);
        check("f_i_rdata",   i_rdata,   32'h13);
        check("f_mem_req_lo", mem_req,  0);
        i_req = 1'b0;
        tick;
        check("f_i_ready_lo", i_ready,  0);
        check("f_no_d_ready", d_cnt - base_d, 0);

        // Store with ack in the 4th request cycle
        mem_delay = 3;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hCAFEF00D; d_wstrb = 4'h3;
        for (int c = 1; c <= 4; c++) begin
            tick;
            check("st_mem_req",   mem_req,   1);
            check("st_mem_we",    mem_we,    1);
            check("st_mem_addr",  mem_addr,  32'h2000);
            check("st_mem_wdata", mem_wdata, 32'hCAFEF00D);
            check("st_mem_wstrb", mem_wstrb, 4'h3);
            check("st_d_ready0",  d_ready,   0);
        end
        tick;
        check("st_d_ready",  d_ready, 1);
        check("st_d_rdata",  d_rdata, 32'h193);
        check("st_mem_req_lo", mem_req, 0);
        d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0;
        tick;
        check("st_d_ready_lo", d_ready, 0);

        // Timeout: memory never answers, late ack afterwards is ignored
        base_d = d_cnt;
        mem_auto = 1'b0; force_ack = 1'b0;
        d_req = 1'b1; d_addr = 32'h300;
        for (int c = 1; c <= 8; c++) begin
            tick;
            check("to_mem_req",  mem_req, 1);
            check("to_d_ready0", d_ready, 0);
            check("to_bus_err0", bus_err, 0);
        end
        tick;
        check("to_d_ready", d_ready,        1);
        check("to_bus_err", bus_err,        1);
        check("to_d_rdata", d_rdata,        0);
        check("to_sticky",  bus_err_sticky, 1);
        check("to_mem_req_lo", mem_req,     0);
        d_req = 1'b0; force_ack = 1'b1;
        tick;
        check("late_d_ready", d_ready,        0);
        check("late_bus_err", bus_err,        0);
        check("late_mem_req", mem_req,        0);
        check("late_sticky",  bus_err_sticky, 1);
        tick;
        check("late2_d_ready", d_ready, 0);
        check("late2_mem_req", mem_req, 0);
        check("late_d_rdata",  d_rdata, 0);
        check("to_d_pulses",   d_cnt - base_d, 1);
        force_ack = 1'b0; mem_auto = 1'b1;

        // Reset during BUSY_D
        mem_delay = 5;
        d_req = 1'b1; d_addr = 32'h500;
        tick; tick;
        check("mr_busy", mem_req, 1);
        base_d = d_cnt;
        #2 reset = 1'b0;
        #1;
        check("mr_mem_req",  mem_req,        0);
        check("mr_mem_addr", mem_addr,       0);
        check("mr_i_rdata",  i_rdata,        0);
        check("mr_sticky",   bus_err_sticky, 0);
        check("mr_d_ready",  d_ready,        0);
        d_req = 1'b0;
        tick; tick; tick;
        check("mr_no_d_ready", d_cnt - base_d, 0);
        reset = 1'b1;
        mem_delay = 0;
        i_req = 1'b1; i_addr = 32'h104;
        tick;
        check("mr_f_mem_req", mem_req, 1);
        tick;
        check("mr_f_i_ready", i_ready, 1);
        check("mr_f_i_rdata", i_rdata, 32'h17);
        i_req = 1'b0;
        tick;

        // Back-to-back fetches with i_req held through i_ready
        base_i = i_cnt;
        cur_addr = 32'h200;
        i_req = 1'b1; i_addr = cur_addr;
        for (int c = 1; c <= 9; c++) begin
            tick;
            check("bb_mem_req", mem_req, (c % 3 == 1));
            check("bb_i_ready", i_ready, (c % 3 == 2));
            if (c % 3 == 2) begin
                check("bb_i_rdata", i_rdata, cur_addr ^ 32'h113);
                cur_addr = cur_addr + 32'h4;
                i_addr = cur_addr;
            end
            if (c == 8) i_req = 1'b0;
        end
        check("bb_i_pulses", i_cnt - base_i, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
